// File: rtl/restoring_divider_param.sv
// Multi-cycle radix-2 restoring divider, one quotient bit per clock, start/busy/valid handshake.
// Define DIV_SIGNED_EN for two's-complement operands (truncating toward zero); default is unsigned.
module restoring_divider_param #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE = 1'b0, DIVIDE = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH+1:0] sh, diff;
    logic             neg;
    logic [WIDTH:0]   a_step;
    logic [WIDTH-1:0] q_step, q_res, r_res, dvd_in, dvs_in;

    // One iteration: shift {A,Q} left, trial-subtract, keep or restore.
    always_comb begin
        sh     = {a_q, q_q[WIDTH-1]};
        diff   = sh - {2'b00, dvs_q};
        neg    = diff[WIDTH+1];
        a_step = neg ? sh[WIDTH:0] : diff[WIDTH:0];
        q_step = {q_q[WIDTH-2:0], ~neg};
    end

`ifdef DIV_SIGNED_EN
    logic qneg_q, qneg_d, rneg_q, rneg_d;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    // Iterate on magnitudes; the quotient sign is the XOR, the remainder follows the dividend.
    always_comb begin
        dvd_in = abs_val(dividend);
        dvs_in = abs_val(divisor);
        q_res  = qneg_q ? (~q_step + WIDTH'(1)) : q_step;
        r_res  = rneg_q ? (~a_step[WIDTH-1:0] + WIDTH'(1)) : a_step[WIDTH-1:0];
    end
`else
    always_comb begin
        dvd_in = dividend;
        dvs_in = divisor;
        q_res  = q_step;
        r_res  = a_step[WIDTH-1:0];
    end
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        state_d = DIVIDE;
                        busy_d  = 1'b1;
                        a_d     = '0;
                        q_d     = dvd_in;
                        dvs_d   = dvs_in;
                        cnt_d   = '0;
`ifdef DIV_SIGNED_EN
                        qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        rneg_d  = dividend[WIDTH-1];
`endif
                    end else begin
                        // Divide-by-zero resolves immediately without iterating.
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        valid_d = 1'b1;
                    end
                end
            end
            DIVIDE: begin
                a_d   = a_step;
                q_d   = q_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    dbz_d   = 1'b0;
                    quo_d   = q_res;
                    rem_d   = r_res;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

`ifdef DIV_SIGNED_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end
`endif

    assign busy        = busy_q;
    assign valid       = valid_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_param.sv
// Directed bench for restoring_divider_param (WIDTH=16): latency, results, handshake, reset abort.
module tb_restoring_divider_param;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             busy, valid, div_by_zero;
    logic [WIDTH-1:0] quotient, remainder;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    int seen;

    restoring_divider_param #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .valid(valid), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [WIDTH-1:0] dd, input logic [WIDTH-1:0] dv);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        tick();
        start    = 1'b0;
    endtask

    // Ticks until valid, bounded; an expired bound shows up as a latency mismatch.
    task automatic wait_valid(output int n);
        n = 0;
        while (!valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic check_result(input string tag, input int exp_lat, input logic [WIDTH-1:0] eq,
                                input logic [WIDTH-1:0] er, input logic edbz);
        int n;
        wait_valid(n);
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_quotient"}, quotient, eq);
        chk({tag, "_remainder"}, remainder, er);
        chk({tag, "_dbz"}, div_by_zero, edbz);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        tick();
        tick();
        chk("reset_busy", busy, 1'b0);
        chk("reset_valid", valid, 1'b0);
        chk("reset_quotient", quotient, 16'h0000);
        chk("reset_remainder", remainder, 16'h0000);
        chk("reset_dbz", div_by_zero, 1'b0);
        rst = 1'b0;
        tick();

        // Basic 100/7
        launch(16'd100, 16'd7);
        chk("basic_busy_after_accept", busy, 1'b1);
        chk("basic_valid_after_accept", valid, 1'b0);
        check_result("basic", 16, 16'd14, 16'd2, 1'b0);
        tick();
        chk("basic_valid_pulse_ends", valid, 1'b0);
        chk("basic_quotient_held", quotient, 16'd14);

        // Range
        launch(16'hFFFF, 16'h0001);
        check_result("range_ffff_1", 16, 16'hFFFF, 16'h0000, 1'b0);
`ifndef DIV_SIGNED_EN
        launch(16'hFFFE, 16'h8001);
        check_result("range_big_divisor", 16, 16'h0001, 16'h7FFD, 1'b0);
`endif

        // Divide-by-zero then a normal division clears the flag
        tick();
        launch(16'h1234, 16'h0000);
        chk("dbz_busy", busy, 1'b0);
        check_result("dbz", 0, 16'hFFFF, 16'h1234, 1'b1);
        tick();
        launch(16'd9, 16'd3);
        check_result("after_dbz", 16, 16'd3, 16'd0, 1'b0);

        // start mid-division is ignored
        tick();
        launch(16'd200, 16'd9);
        for (int i = 0; i < 5; i++) tick();
        launch(16'd1000, 16'd3);
        check_result("ignored_start", 10, 16'd22, 16'd2, 1'b0);

        // start in the valid cycle is accepted
        launch(16'd50, 16'd5);
        chk("b2b_busy", busy, 1'b1);
        check_result("b2b", 16, 16'd10, 16'd0, 1'b0);

        // Reset at iteration 8 aborts at once, with no later valid
        tick();
        launch(16'd1000, 16'd3);
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_valid", valid, 1'b0);
        chk("abort_quotient", quotient, 16'h0000);
        chk("abort_remainder", remainder, 16'h0000);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid) seen++;
        end
        chk("abort_no_valid", seen, 0);
        launch(16'd1000, 16'd3);
        check_result("after_abort", 16, 16'd333, 16'd1, 1'b0);

`ifdef DIV_SIGNED_EN
        tick();
        launch(16'hFFF9, 16'h0002);
        check_result("signed_m7_2", 16, 16'hFFFD, 16'hFFFF, 1'b0);
        tick();
        launch(16'h0007, 16'hFFFE);
        check_result("signed_7_m2", 16, 16'hFFFD, 16'h0001, 1'b0);
        tick();
        launch(16'h8000, 16'hFFFF);
        check_result("signed_wrap", 16, 16'h8000, 16'h0000, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
